// File: rtl/pwm_deadtime_gen_pkg.sv
// Shared types and default build constants for the complementary PWM generator.
package pwm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOW_ON,
    DT_RISE,
    HIGH_ON,
    DT_FALL
  } pwm_state_t;

  localparam int DEF_CNT_MAX = 100;
  localparam int DEF_DEAD    = 4;
  localparam int DEF_W       = 8;
  localparam int DCNT_W      = 8;

endpackage

// File: rtl/pwm_deadtime_gen_if.sv
// Bundles the period count, duty programming and gate-drive outputs of the PWM block.
interface pwm_deadtime_gen_if import pwm_pkg::*; #(
  parameter int W = DEF_W
) ();

  logic         en;
  logic [W-1:0] count;
  logic [W-1:0] duty_in;
  logic         duty_wr;
  logic         pwm_h;
  logic         pwm_l;
  logic         period_start;

  modport master (
    output en, count, duty_in, duty_wr,
    input  pwm_h, pwm_l, period_start
  );

  modport slave (
    input  en, count, duty_in, duty_wr,
    output pwm_h, pwm_l, period_start
  );

endinterface

// File: rtl/pwm_deadtime_gen_fsm.sv
// Dead-time state machine: turns the registered compare into a non-overlapping
// high/low gate pair, refusing to emit pulses shorter than the dead time.
module pwm_deadtime_fsm import pwm_pkg::*; #(
  parameter int DEAD = DEF_DEAD
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw_q,
  output logic pwm_h,
  output logic pwm_l
);

  localparam bit                BYPASS  = (DEAD == 0);
  localparam logic [DCNT_W-1:0] DT_LOAD = BYPASS ? '0 : DCNT_W'(DEAD - 1);

  pwm_state_t        state, state_nx;
  logic [DCNT_W-1:0] dcnt, dcnt_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      dcnt  <= dcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_nx = BYPASS ? LOW_ON : DT_FALL;
          dcnt_nx  = DT_LOAD;
        end
      end
      LOW_ON: begin
        if (raw_q) begin
          state_nx = BYPASS ? HIGH_ON : DT_RISE;
          dcnt_nx  = DT_LOAD;
        end
      end
      HIGH_ON: begin
        if (!raw_q) begin
          state_nx = BYPASS ? LOW_ON : DT_FALL;
          dcnt_nx  = DT_LOAD;
        end
      end
      // On expiry the gate only turns on if the compare still agrees; otherwise
      // the opposite dead time is restarted so no runt pulse escapes.
      DT_RISE: begin
        if (dcnt == '0) begin
          state_nx = raw_q ? HIGH_ON : DT_FALL;
          dcnt_nx  = DT_LOAD;
        end else begin
          dcnt_nx = dcnt - 1'b1;
        end
      end
      DT_FALL: begin
        if (dcnt == '0) begin
          state_nx = raw_q ? DT_RISE : LOW_ON;
          dcnt_nx  = DT_LOAD;
        end else begin
          dcnt_nx = dcnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!en) begin
      state_nx = IDLE;
      dcnt_nx  = '0;
    end
  end

  assign pwm_h = (state == HIGH_ON);
  assign pwm_l = (state == LOW_ON);

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM with double-buffered duty applied at period boundaries and
// a dead-time FSM guaranteeing the two gate drives never overlap.
module pwm_deadtime_gen import pwm_pkg::*; #(
  parameter int CNT_MAX = DEF_CNT_MAX,
  parameter int W       = DEF_W,
  parameter int DEAD    = DEF_DEAD
) (
  input logic               clk,
  input logic               rst,
  pwm_deadtime_gen_if.slave bus
);

  localparam logic [W-1:0] DUTY_MAX = W'(CNT_MAX + 1);
  localparam logic [W-1:0] CNT_LAST = W'(CNT_MAX);

  function automatic logic [W-1:0] clamp_duty(input logic [W-1:0] d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

  logic [W-1:0] prev_count;
  logic [W-1:0] pending;
  logic [W-1:0] active;
  logic         upd;
  logic         raw_q;
  logic         period_start_q;
  logic         bnd;

  assign bnd = (bus.count == '0) && (prev_count != '0);

  // Stage 1: boundary detect, duty double-buffer and registered compare.
  // A write coinciding with a boundary lands in pending for the next period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_count     <= CNT_LAST;
      pending        <= '0;
      active         <= '0;
      upd            <= 1'b0;
      raw_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      prev_count     <= bus.count;
      period_start_q <= bnd;
      raw_q          <= (bus.count < active);
      if (bnd && upd)
        active <= pending;
      if (bus.duty_wr) begin
        pending <= clamp_duty(bus.duty_in);
        upd     <= 1'b1;
      end else if (bnd) begin
        upd <= 1'b0;
      end
    end
  end

  // Stage 2: dead-time state machine and gate decode.
  pwm_deadtime_fsm #(
    .DEAD (DEAD)
  ) u_fsm (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .raw_q (raw_q),
    .pwm_h (bus.pwm_h),
    .pwm_l (bus.pwm_l)
  );

  assign bus.period_start = period_start_q;

endmodule

// File: doc/pwm_deadtime_gen.md
# pwm_deadtime_gen

Consumes the free-running 0..CNT_MAX period count produced by the upstream `program_counter` and drives a complementary high/low PWM pair with programmable duty and fixed dead time. Duty updates are double-buffered and take effect only at a period boundary. The dead-time state machine guarantees that `pwm_h` and `pwm_l` are never both high.

## Interface
- `CNT_MAX`, 100: last value of the upstream count; the period is CNT_MAX+1 cycles.
- `W`, 8: width of the count and duty buses.
- `DEAD`, 4: dead-time length in clk cycles, range 0..255.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `en`  in  1  output enable; low forces both outputs low.
- `count`  in  W  period count from upstream, 0..CNT_MAX.
- `duty_in`  in  W  requested duty in count units, 0..CNT_MAX+1.
- `duty_wr`  in  1  single-cycle strobe; captures `duty_in` into the pending register.
- `pwm_h`  out  1  high-side gate drive.
- `pwm_l`  out  1  low-side gate drive.
- `period_start`  out  1  one-cycle pulse, registered, marks each period boundary.

## Operation
- **Duty capture.** On `duty_wr`, `pending <= min(duty_in, CNT_MAX+1)` and `upd <= 1`. A later write before the boundary overwrites `pending`.
- **Boundary.** `bnd = (count == 0) && (prev_count != 0)`.
  - `prev_count` is registered and resets to CNT_MAX, so the first count of 0 after reset is a boundary.
  - On `bnd` with `upd=1`: `active <= pending`, `upd <= 0`.
- **Write and boundary in the same cycle.** `active` takes the old `pending`. The new value lands in `pending` with `upd=1` and is applied at the next boundary.
- **Compare.** `raw_q <= (count < active)`, registered.
  - `active = 0` gives constant low.
  - `active = CNT_MAX+1` gives constant high.
- **FSM states:** IDLE, LOW_ON, DT_RISE, HIGH_ON, DT_FALL. Outputs are Moore-decoded from registered state:
  - LOW_ON: `pwm_l = 1`, `pwm_h = 0`.
  - HIGH_ON: `pwm_h = 1`, `pwm_l = 0`.
  - All other states: both outputs 0.
- **FSM transitions:**
  - IDLE → DT_FALL when `en = 1`.
  - LOW_ON → DT_RISE when `raw_q = 1`.
  - HIGH_ON → DT_FALL when `raw_q = 0`.
  - DT_RISE on expiry: → HIGH_ON if `raw_q = 1`, else → DT_FALL (reload).
  - DT_FALL on expiry: → LOW_ON if `raw_q = 0`, else → DT_RISE (reload).
- **Dead-time counter.** Loaded with DEAD-1 on entry to DT_RISE or DT_FALL. Expiry is when the counter is 0.
- **DEAD = 0.** DT states are bypassed: LOW_ON ↔ HIGH_ON directly, and IDLE → LOW_ON.
- **Enable low.** `en = 0` in any state → IDLE next cycle, so both outputs are low one cycle later. `duty` registers are unaffected.
- **Short pulses.** If the high window is no longer than DEAD, `pwm_h` never asserts: DT_RISE expires with `raw_q = 0`. No runt pulses are produced.
- **Invariant:** `pwm_h & pwm_l == 0` in every cycle.

## Timing
- **Reset values:** `pwm_h = 0`, `pwm_l = 0`, `period_start = 0`, state IDLE, `active = 0`, `pending = 0`, `upd = 0`, `raw_q = 0`, dead counter 0.
- **count → raw_q:** 1 cycle. The state changes on the following edge.
- **Falling edge of duty window.** Count reaches `active` at cycle t:
  - `pwm_h` falls after edge t+2.
  - `pwm_l` rises after edge t+2+DEAD.
- **Rising edge of duty window** is symmetric: the window starts at count 0, giving `pwm_l` low at t+2 and `pwm_h` high at t+2+DEAD.
- **`period_start`:** high for the one cycle following the edge where `bnd` was sampled.
- **New duty:** first affects `raw_q` on the cycle after the boundary.
- **Reset mid-period:** all state returns to reset values at the next edge. No partial dead time is honoured, because both outputs are already low in reset.

## Structure
- **`pwm_pkg`:** state enum `pwm_state_t`, default constants for CNT_MAX and DEAD, and the width W.
- **Sub-module `pwm_deadtime_fsm`:**
  - Contains the state register, dead counter and output decode.
  - Input: `raw_q`, `en`. Outputs: `pwm_h`, `pwm_l`.
  - The top level holds the duty double-buffer, boundary detect and compare.

## Test plan
- **Basic waveform.** Reset, `en = 1`, DEAD=4, write duty=50 before the first boundary.
  - Required per period of 101: `pwm_h` high 46 cycles, `pwm_l` high 47 cycles, and 4-cycle gaps at both transitions.
- **Double buffer.** Write 30 at count=10, then 70 at count=60.
  - Required: duty 70 applies from the next `period_start`; 30 is never seen. Repeat with the write exactly at count=0 and check the one-period deferral.
- **Extremes.**
  - duty=0: `pwm_l` constant 1 after startup dead time.
  - duty=101: `pwm_h` constant 1.
  - duty=200: clamped to 101, same as 101.
- **Short pulse.** DEAD=4 with duty 3 and duty 4 → `pwm_h` never asserts. Duty 5 → `pwm_h` is high for 1 cycle.
- **DEAD=0 build.** duty=50 → `pwm_h` is high for exactly 50 cycles and the outputs are complementary every cycle.
- **Enable and reset.** Drop `en` mid-HIGH_ON, then drop `rst` mid-DT_RISE.
  - Required: both outputs 0 within 1 cycle, the registers hold their reset values, and the `pwm_h & pwm_l` assertion never fires.
